// File: rtl/cp0_exc.sv
// cp0_exc: coprocessor-0 and exception unit at the commit point (MEM stage).
// It owns Status, Cause, EPC, Count and Compare. It raises the pipeline flush
// and redirect PC for exceptions, interrupts and ERET, and it serves mfc0/mtc0.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   inst_valid, pc      committing instruction is real, and its PC
//   in_delay_slot       committing instruction sits in a branch delay slot
//   ov, syscall, brk,
//   ri, eret            exception / return sources at the commit point
//   hw_int[5:0]         level-sensitive external interrupt lines
//   we, waddr, wdata    mtc0 write port
//   raddr, rdata        mfc0 read port (combinational, no write bypass)
//   exc_flush, exc_pc   flush IF..MEM and redirect target (combinational)
//   timer_int           registered Count==Compare pending flag
//
// Register map: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
//
// FSM: none. All control is single-cycle, decided from the current
// architectural state and the commit-point inputs.
module cp0_exc #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] pc,
  input  logic        in_delay_slot,
  input  logic        ov,
  input  logic        syscall,
  input  logic        brk,
  input  logic        ri,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  output logic        exc_flush,
  output logic [31:0] exc_pc,
  output logic        timer_int
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'h00;
  localparam logic [4:0] EXC_SYS = 5'h08;
  localparam logic [4:0] EXC_BP  = 5'h09;
  localparam logic [4:0] EXC_RI  = 5'h0A;
  localparam logic [4:0] EXC_OV  = 5'h0C;

  // Only the writable fields of Status and Cause are stored; the remaining
  // bits are constant (Status keeps its reset image, Cause reads 0).
  logic [7:0]  im_q,      im_d;
  logic        exl_q,     exl_d;
  logic        ie_q,      ie_d;
  logic        bd_q,      bd_d;
  logic [7:0]  ip_q,      ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q,     epc_d;
  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_q,   timer_d;
  logic        tick_q,    tick_d;

  logic        int_req;
  logic        exc_take;
  logic        eret_take;
  logic        wr_en;
  logic [4:0]  exc_code;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  assign status_rd = (STATUS_RST & ~32'h0000_FF03) |
                     {16'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_rd  = {bd_q, 15'b0, ip_q, 1'b0, exccode_q, 2'b0};
  assign timer_int = timer_q;

  always_comb begin
    int_req   = ie_q & ~exl_q & (|(ip_q & im_q));
    // Gating with rst keeps the flush quiet during the reset cycle.
    exc_take  = rst & inst_valid & (int_req | ri | ov | syscall | brk);
    eret_take = rst & inst_valid & eret & ~exc_take;
    wr_en     = we & ~exc_take;

    exc_code = EXC_BP;
    if (int_req)      exc_code = EXC_INT;
    else if (ri)      exc_code = EXC_RI;
    else if (ov)      exc_code = EXC_OV;
    else if (syscall) exc_code = EXC_SYS;

    exc_flush = exc_take | eret_take;
    exc_pc    = 32'h0;
    if (exc_take)       exc_pc = EXC_VECTOR;
    else if (eret_take) exc_pc = epc_q;
  end

  always_comb begin
    rdata = 32'h0;
    case (raddr)
      REG_COUNT:   rdata = count_q;
      REG_COMPARE: rdata = compare_q;
      REG_STATUS:  rdata = status_rd;
      REG_CAUSE:   rdata = cause_rd;
      REG_EPC:     rdata = epc_q;
      default:     rdata = 32'h0;
    endcase
  end

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    ip_d      = ip_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    compare_d = compare_q;
    timer_d   = timer_q;
    tick_d    = ~tick_q;
    count_d   = tick_q ? count_q + 32'd1 : count_q;

    // Hardware IP bits are resampled every cycle; timer shares line 5.
    ip_d[7:2] = {hw_int[5] | timer_q, hw_int[4:0]};

    if (count_q == compare_q) timer_d = 1'b1;

    if (wr_en) begin
      case (waddr)
        REG_COUNT:   count_d = wdata;
        REG_COMPARE: begin
          compare_d = wdata;
          timer_d   = 1'b0;  // clear beats a same-cycle match
        end
        REG_STATUS: begin
          im_d  = wdata[15:8];
          exl_d = wdata[1];
          ie_d  = wdata[0];
        end
        REG_CAUSE:   ip_d[1:0] = wdata[9:8];
        REG_EPC:     epc_d = wdata;
        default: ;
      endcase
    end

    // Exception/ERET updates come last so they win over a same-cycle mtc0.
    if (exc_take) begin
      exccode_d = exc_code;
      exl_d     = 1'b1;
      if (!exl_q) begin
        epc_d = in_delay_slot ? pc - 32'd4 : pc;
        bd_d  = in_delay_slot;
      end
    end else if (eret_take) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      im_q      <= STATUS_RST[15:8];
      exl_q     <= STATUS_RST[1];
      ie_q      <= STATUS_RST[0];
      bd_q      <= 1'b0;
      ip_q      <= 8'h0;
      exccode_q <= 5'h0;
      epc_q     <= 32'h0;
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      timer_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      timer_q   <= timer_d;
      tick_q    <= tick_d;
    end
  end

endmodule
